// File: rtl/bkg_pkg.sv
// Shared definitions for the scrolling background mapper: VGA geometry,
// colour and scroll-step types, the handshake slot states and the
// single-wrap modular add used by both the address datapath and the
// scroll offset update.
package bkg_pkg;

   localparam int VGA_SCREEN_W = 640;
   localparam int VGA_SCREEN_H = 480;
   localparam int COORD_W      = 10;

   typedef struct packed {
      logic [3:0] red;
      logic [3:0] green;
      logic [3:0] blue;
   } rgb4_t;

   typedef logic signed [7:0] scroll_step_t;

   // One-entry request slot: empty accepts a new step, full waits for a frame boundary
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_t;

   // Adds delta to base and folds the result back into 0..modulus-1 with a
   // single correction; callers guarantee the sum lies in -modulus..2*modulus-1.
   function automatic int wrap_add(input int base, input int delta, input int modulus);
      int sum;
      sum = base + delta;
      if (sum < 0) begin
         sum = sum + modulus;
      end else if (sum >= modulus) begin
         sum = sum - modulus;
      end
      return sum;
   endfunction

endpackage

// File: rtl/bkg_scroll_mapper_if.sv
// Scroll request channel from the game-logic FSM to the background mapper.
// The master holds scroll_step stable while scroll_valid is high; a step
// is transferred on any cycle where scroll_valid and scroll_ready are both 1.
interface bkg_scroll_mapper_if;
   import bkg_pkg::*;

   scroll_step_t scroll_step;
   logic         scroll_valid;
   logic         scroll_ready;

   modport master (
      output scroll_step,
      output scroll_valid,
      input  scroll_ready
   );

   modport slave (
      input  scroll_step,
      input  scroll_valid,
      output scroll_ready
   );

endinterface

// File: rtl/bkg_scroll_ctrl.sv
// Scroll controller: buffers one requested step and applies it to the
// horizontal offset at the first pixel of the first non-visible line, so the
// offset never moves while visible lines are drawn.  frame_tick is
// registered and rises together with the new scroll_x value.
module bkg_scroll_ctrl
   import bkg_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int SCREEN_H = VGA_SCREEN_H,
   parameter int ADDR_W   = 20
) (
   input  logic                vga_clk,
   input  logic                reset,
   input  logic [COORD_W-1:0]  DrawX,
   input  logic [COORD_W-1:0]  DrawY,
   bkg_scroll_mapper_if.slave  scroll_bus,
   output logic [ADDR_W-1:0]   scroll_x,
   output logic                frame_tick
);

   slot_state_t       state;
   slot_state_t       state_next;
   scroll_step_t      step_q;
   logic              take_step;
   logic              apply_now;
   logic              apply_event;
   logic [ADDR_W-1:0] scroll_x_next;

   assign apply_event = (DrawX == '0) && (DrawY == COORD_W'(SCREEN_H));
   assign scroll_bus.scroll_ready = (state == SLOT_EMPTY);

   // Next slot state: accept a step when empty, release it at the frame boundary
   always_comb begin
      state_next = state;
      take_step  = 1'b0;
      apply_now  = 1'b0;
      case (state)
         SLOT_EMPTY: begin
            if (scroll_bus.scroll_valid) begin
               take_step  = 1'b1;
               state_next = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            if (apply_event) begin
               apply_now  = 1'b1;
               state_next = SLOT_EMPTY;
            end
         end
         default: state_next = SLOT_EMPTY;
      endcase
   end

   // Offset plus signed step, folded back into 0..IMG_W-1
   always_comb begin
      scroll_x_next = ADDR_W'(wrap_add(int'(scroll_x), int'(step_q), IMG_W));
   end

   // Slot, captured step, offset and tick registers; reset drops any pending step
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state      <= SLOT_EMPTY;
         step_q     <= '0;
         scroll_x   <= '0;
         frame_tick <= 1'b0;
      end else begin
         state      <= state_next;
         frame_tick <= apply_now;
         if (take_step) begin
            step_q <= scroll_bus.scroll_step;
         end
         if (apply_now) begin
            scroll_x <= scroll_x_next;
         end
      end
   end

endmodule

// File: rtl/bkg_scroll_mapper.sv
// Scrolling background mapper: beam coordinates -> background ROM address
// with power-of-two upscaling and horizontal wrap, then ROM and palette
// lookup with blank/out-of-bounds flags delayed to match.  Coordinate to RGB
// latency is ROM_LAT+2 cycles, with no bubbles.
// Optional build macro: BKG_SCROLL_TRANSPARENT_EN adds bkg_transparent,
// a colour-key flag aligned with RGB (palette index 0 on visible pixels).
module bkg_scroll_mapper
   import bkg_pkg::*;
#(
   parameter int IMG_W    = 640,
   parameter int IMG_H    = 480,
   parameter int SCREEN_W = VGA_SCREEN_W,
   parameter int SCREEN_H = VGA_SCREEN_H,
   parameter int SCALE_SH = 0,
   parameter int IDX_W    = 2,
   parameter int ADDR_W   = 20,
   parameter int ROM_LAT  = 1
) (
   input  logic                vga_clk,
   input  logic                reset,
   input  logic [COORD_W-1:0]  DrawX,
   input  logic [COORD_W-1:0]  DrawY,
   input  logic                blank,
   bkg_scroll_mapper_if.slave  scroll_bus,
   output logic [ADDR_W-1:0]   scroll_x,
   output logic                frame_tick,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [IDX_W-1:0]    rom_q,
   output logic [3:0]          red,
   output logic [3:0]          green,
   output logic [3:0]          blue,
   output logic [IDX_W-1:0]    pal_index,
   input  logic [3:0]          pal_red,
   input  logic [3:0]          pal_green,
   input  logic [3:0]          pal_blue
`ifdef BKG_SCROLL_TRANSPARENT_EN
   ,
   output logic                bkg_transparent
`endif
);

   // Parameter sanity: the scaled screen must fit the image, the ROM latency
   // must be supported and the address bus must reach every source pixel.
   if ((SCREEN_W >> SCALE_SH) > IMG_W) begin : g_bad_width
      $error("bkg_scroll_mapper: scaled screen wider than IMG_W");
   end
   if ((ROM_LAT < 1) || (ROM_LAT > 3)) begin : g_bad_lat
      $error("bkg_scroll_mapper: ROM_LAT must be 1..3");
   end
   if ((longint'(1) << ADDR_W) < (longint'(IMG_W) * longint'(IMG_H))) begin : g_bad_addr
      $error("bkg_scroll_mapper: ADDR_W too narrow for IMG_W*IMG_H");
   end

   int                src_x;
   int                src_y;
   int                wrapped_x;
   logic              oob_next;
   logic [ADDR_W-1:0] addr_next;
   logic [ROM_LAT:0]  blank_pipe;
   logic [ROM_LAT:0]  oob_pipe;
   logic              show_pixel;
   rgb4_t             pal_colour;
   rgb4_t             rgb_q;

   bkg_scroll_ctrl #(
      .IMG_W    (IMG_W),
      .SCREEN_H (SCREEN_H),
      .ADDR_W   (ADDR_W)
   ) u_ctrl (
      .vga_clk    (vga_clk),
      .reset      (reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .scroll_bus (scroll_bus),
      .scroll_x   (scroll_x),
      .frame_tick (frame_tick)
   );

   // Stage A address math: scale down, add scroll with one wrap, flag rows below the image
   always_comb begin
      src_x     = int'(DrawX) >> SCALE_SH;
      src_y     = int'(DrawY) >> SCALE_SH;
      wrapped_x = wrap_add(src_x, int'(scroll_x), IMG_W);
      oob_next  = (src_y >= IMG_H);
      addr_next = oob_next ? '0 : ADDR_W'(src_y * IMG_W + wrapped_x);
   end

   // Stage A register plus blank/oob delay line matched to the ROM latency
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         rom_address <= '0;
         blank_pipe  <= '0;
         oob_pipe    <= '0;
      end else begin
         rom_address <= addr_next;
         blank_pipe  <= {blank_pipe[ROM_LAT-1:0], blank};
         oob_pipe    <= {oob_pipe[ROM_LAT-1:0], oob_next};
      end
   end

   assign pal_index  = rom_q;
   assign show_pixel = blank_pipe[ROM_LAT] && !oob_pipe[ROM_LAT];

   // Gather the combinational palette answer into one colour word
   always_comb begin
      pal_colour.red   = pal_red;
      pal_colour.green = pal_green;
      pal_colour.blue  = pal_blue;
   end

   // Output register: palette colour on visible in-image pixels, black elsewhere
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         rgb_q <= '0;
      end else begin
         rgb_q <= show_pixel ? pal_colour : '0;
      end
   end

   assign red   = rgb_q.red;
   assign green = rgb_q.green;
   assign blue  = rgb_q.blue;

`ifdef BKG_SCROLL_TRANSPARENT_EN
   // Colour-key flag registered alongside RGB so sprites see it on the same pixel
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         bkg_transparent <= 1'b0;
      end else begin
         bkg_transparent <= show_pixel && (rom_q == '0);
      end
   end
`else
   // Without the colour-key option only the RGB register is produced.
`endif

endmodule

// File: tb/tb_bkg_scroll_mapper.sv
// Bench for bkg_scroll_mapper: two instances (640x480 unscaled ROM_LAT=1 and
// 320x200 scaled-by-2 ROM_LAT=2) share the beam stimulus and scroll requests.
// A behavioural model tracks the scroll offset with modulo arithmetic and
// predicts address, colour and handshake outputs every cycle.
module tb_bkg_scroll_mapper;
   import bkg_pkg::*;

   localparam int A_W = 640, A_H = 480, A_SH = 0, A_LAT = 1;
   localparam int B_W = 320, B_H = 200, B_SH = 1, B_LAT = 2;
   localparam int MAXC = 8192;

   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank;

   logic [19:0] scroll_x_a, rom_address_a, scroll_x_b, rom_address_b;
   logic        frame_tick_a, frame_tick_b;
   logic [1:0]  rom_q_a, rom_q_b, pal_index_a, pal_index_b, rom_b_d1;
   logic [3:0]  red_a, green_a, blue_a, red_b, green_b, blue_b;
   logic [3:0]  pal_red_a, pal_green_a, pal_blue_a, pal_red_b, pal_green_b, pal_blue_b;
`ifdef BKG_SCROLL_TRANSPARENT_EN
   logic        bkg_transparent_a, bkg_transparent_b;
`endif

   bkg_scroll_mapper_if if_a ();
   bkg_scroll_mapper_if if_b ();

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   int exp_rgb_a [MAXC];
   int exp_rgb_b [MAXC];
   int exp_tr_a  [MAXC];
   bit rst_hist  [MAXC];

   int m_scroll_a, m_scroll_b, m_step, m_tick;
   bit m_pending;
   bit req_active;
   int req_step;
   int req_q [$];

   always #5 vga_clk = ~vga_clk;

   bkg_scroll_mapper #(
      .IMG_W(A_W), .IMG_H(A_H), .SCREEN_W(640), .SCREEN_H(480), .SCALE_SH(A_SH),
      .IDX_W(2), .ADDR_W(20), .ROM_LAT(A_LAT)
   ) dut_a (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .scroll_bus(if_a.slave), .scroll_x(scroll_x_a), .frame_tick(frame_tick_a),
      .rom_address(rom_address_a), .rom_q(rom_q_a),
      .red(red_a), .green(green_a), .blue(blue_a), .pal_index(pal_index_a),
      .pal_red(pal_red_a), .pal_green(pal_green_a), .pal_blue(pal_blue_a)
`ifdef BKG_SCROLL_TRANSPARENT_EN
      , .bkg_transparent(bkg_transparent_a)
`endif
   );

   bkg_scroll_mapper #(
      .IMG_W(B_W), .IMG_H(B_H), .SCREEN_W(640), .SCREEN_H(480), .SCALE_SH(B_SH),
      .IDX_W(2), .ADDR_W(20), .ROM_LAT(B_LAT)
   ) dut_b (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .scroll_bus(if_b.slave), .scroll_x(scroll_x_b), .frame_tick(frame_tick_b),
      .rom_address(rom_address_b), .rom_q(rom_q_b),
      .red(red_b), .green(green_b), .blue(blue_b), .pal_index(pal_index_b),
      .pal_red(pal_red_b), .pal_green(pal_green_b), .pal_blue(pal_blue_b)
`ifdef BKG_SCROLL_TRANSPARENT_EN
      , .bkg_transparent(bkg_transparent_b)
`endif
   );

   // Background image content: a fixed hash of the address
   function automatic logic [1:0] rom_fn(input logic [19:0] a);
      return a[1:0] ^ a[5:4] ^ a[9:8] ^ a[13:12];
   endfunction

   // Palette: every index, including 0, maps to a non-black colour
   function automatic logic [11:0] pal_fn(input logic [1:0] i);
      return {2'b10, i, i, 2'b01, 4'({2'b00, i} * 4'd3 + 4'd2)};
   endfunction

   // Synchronous ROMs with the latency each instance expects
   always @(posedge vga_clk) begin
      rom_q_a  <= rom_fn(rom_address_a);
      rom_b_d1 <= rom_fn(rom_address_b);
      rom_q_b  <= rom_b_d1;
   end

   assign {pal_red_a, pal_green_a, pal_blue_a} = pal_fn(pal_index_a);
   assign {pal_red_b, pal_green_b, pal_blue_b} = pal_fn(pal_index_b);

   function automatic int mod_w(input int v, input int w);
      return ((v % w) + w) % w;
   endfunction

   // What a pixel should look like given the offset in force when it is sampled
   function automatic void model_pixel(input int x, input int y, input int bl, input int scroll,
                                       input int w, input int h, input int sh,
                                       output int addr, output int col, output int tr);
      int sx, sy;
      sx = ((x >> sh) + scroll) % w;
      sy = y >> sh;
      if (sy >= h) begin
         addr = 0; col = 0; tr = 0;
      end else begin
         addr = sy * w + sx;
         col  = (bl != 0) ? int'(pal_fn(rom_fn(20'(addr)))) : 0;
         tr   = ((bl != 0) && (rom_fn(20'(addr)) == 2'd0)) ? 1 : 0;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
      end
   endtask

   // Drive one beam cycle, advance the model across the clock edge and compare
   task automatic applyStimulus(input int x, input int y, input int bl, input bit rst);
      int addr_a, col_a, tr_a, addr_b, col_b, tr_b, e;
      bit transfer, apply;
      if (!req_active && req_q.size() > 0) begin
         req_active = 1'b1;
         req_step   = req_q.pop_front();
      end
      DrawX = 10'(x); DrawY = 10'(y); blank = (bl != 0); reset = rst;
      if_a.scroll_valid = req_active; if_a.scroll_step = 8'(req_step);
      if_b.scroll_valid = req_active; if_b.scroll_step = 8'(req_step);
      model_pixel(x, y, bl, m_scroll_a, A_W, A_H, A_SH, addr_a, col_a, tr_a);
      model_pixel(x, y, bl, m_scroll_b, B_W, B_H, B_SH, addr_b, col_b, tr_b);
      exp_rgb_a[cyc] = col_a; exp_rgb_b[cyc] = col_b; exp_tr_a[cyc] = tr_a;
      rst_hist[cyc]  = rst;
      transfer = req_active && !m_pending && !rst;
      apply    = m_pending && (x == 0) && (y == 480) && !rst;
      @(posedge vga_clk);
      if (rst) begin
         m_pending = 1'b0; m_scroll_a = 0; m_scroll_b = 0; m_tick = 0;
      end else begin
         m_tick = apply ? 1 : 0;
         if (apply) begin
            m_scroll_a = mod_w(m_scroll_a + m_step, A_W);
            m_scroll_b = mod_w(m_scroll_b + m_step, B_W);
            m_pending  = 1'b0;
         end
         if (transfer) begin
            m_pending = 1'b1;
            m_step    = req_step;
         end
      end
      if (transfer) req_active = 1'b0;
      #1;
      checkOutput("scroll_x_a", 32'(scroll_x_a), 32'(m_scroll_a));
      checkOutput("scroll_x_b", 32'(scroll_x_b), 32'(m_scroll_b));
      checkOutput("frame_tick_a", 32'(frame_tick_a), 32'(m_tick));
      checkOutput("frame_tick_b", 32'(frame_tick_b), 32'(m_tick));
      checkOutput("ready_a", 32'(if_a.scroll_ready), 32'(!m_pending));
      checkOutput("ready_b", 32'(if_b.scroll_ready), 32'(!m_pending));
      checkOutput("rom_addr_a", 32'(rom_address_a), rst ? 32'd0 : 32'(addr_a));
      checkOutput("rom_addr_b", 32'(rom_address_b), rst ? 32'd0 : 32'(addr_b));
      if (cyc >= A_LAT + 1) begin
         e = exp_rgb_a[cyc - A_LAT - 1];
         for (int k = cyc - A_LAT - 1; k <= cyc; k++) if (rst_hist[k]) e = 0;
         checkOutput("rgb_a", 32'({red_a, green_a, blue_a}), 32'(e));
`ifdef BKG_SCROLL_TRANSPARENT_EN
         e = exp_tr_a[cyc - A_LAT - 1];
         for (int k = cyc - A_LAT - 1; k <= cyc; k++) if (rst_hist[k]) e = 0;
         checkOutput("transparent_a", 32'(bkg_transparent_a), 32'(e));
`endif
      end
      if (cyc >= B_LAT + 1) begin
         e = exp_rgb_b[cyc - B_LAT - 1];
         for (int k = cyc - B_LAT - 1; k <= cyc; k++) if (rst_hist[k]) e = 0;
         checkOutput("rgb_b", 32'({red_b, green_b, blue_b}), 32'(e));
      end
      cyc++;
   endtask

   task automatic randomPixel();
      int x, y, bl;
      x  = int'($urandom_range(0, 639));
      y  = int'($urandom_range(0, 524));
      bl = ((y < 480) && ($urandom_range(0, 7) != 0)) ? 1 : 0;
      applyStimulus(x, y, bl, 1'b0);
   endtask

   // A few ordinary pixels followed by the frame-boundary pixel
   task automatic runFrame(input int n);
      for (int k = 0; k < n; k++) randomPixel();
      applyStimulus(0, 480, 0, 1'b0);
   endtask

   initial begin
      m_scroll_a = 0; m_scroll_b = 0; m_step = 0; m_tick = 0;
      m_pending = 1'b0; req_active = 1'b0; req_step = 0;

      for (int k = 0; k < 3; k++) applyStimulus(0, 0, 0, 1'b1);
      checkOutput("reset_ready", 32'(if_a.scroll_ready), 32'd1);

      applyStimulus(5, 2, 1, 1'b0);
      checkOutput("addr_5_2", 32'(rom_address_a), 32'd1285);
      applyStimulus(7, 9, 1, 1'b0);
      checkOutput("addr_b_7_9", 32'(rom_address_b), 32'd1283);
      for (int k = 0; k < 6; k++) randomPixel();

      req_q.push_back(-10);
      runFrame(4);
      checkOutput("scroll_630", 32'(scroll_x_a), 32'd630);
      applyStimulus(15, 3, 1, 1'b0);
      checkOutput("addr_wrap", 32'(rom_address_a), 32'd1925);
      req_q.push_back(20);
      runFrame(4);
      checkOutput("scroll_10", 32'(scroll_x_a), 32'd10);
      req_q.push_back(-20);
      runFrame(4);
      checkOutput("scroll_back_630", 32'(scroll_x_a), 32'd630);

      applyStimulus(0, 0, 0, 1'b1);
      req_q.push_back(4);
      req_q.push_back(8);
      runFrame(5);
      checkOutput("bp_first", 32'(scroll_x_a), 32'd4);
      checkOutput("bp_tick", 32'(frame_tick_a), 32'd1);
      runFrame(5);
      checkOutput("bp_final", 32'(scroll_x_a), 32'd12);

      applyStimulus(10, 420, 1, 1'b0);
      checkOutput("oob_addr_b", 32'(rom_address_b), 32'd0);
      for (int k = 0; k < 4; k++) applyStimulus(20 + k, 420, 1, 1'b0);

      req_q.push_back(50);
      for (int k = 0; k < 3; k++) applyStimulus(100 + k, 100, 1, 1'b0);
      applyStimulus(103, 100, 1, 1'b1);
      applyStimulus(104, 100, 1, 1'b0);
      checkOutput("ready_after_reset", 32'(if_a.scroll_ready), 32'd1);
      applyStimulus(0, 480, 0, 1'b0);
      checkOutput("mid_reset_scroll", 32'(scroll_x_a), 32'd0);
      checkOutput("mid_reset_tick", 32'(frame_tick_a), 32'd0);

      for (int i = 0; i < 2500; i++) begin
         if (req_q.size() == 0 && !req_active && $urandom_range(0, 19) == 0)
            req_q.push_back(int'($urandom_range(0, 200)) - 100);
         if ((i % 250) == 249) applyStimulus(0, 480, 0, 1'b0);
         else if ($urandom_range(0, 699) == 0) applyStimulus(0, 0, 0, 1'b1);
         else randomPixel();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bkg_scroll_mapper.md
Name: bkg_scroll_mapper

Overview:
Parametrised successor to the fixed-size background mapper. It maps VGA beam coordinates (DrawX, DrawY) to a background ROM address with integer power-of-two upscaling and horizontal scrolling with wrap-around. It pipelines the ROM and palette lookup and aligns blank to the pixel data. It sits between the VGA controller and the per-level background ROM/palette; scroll requests come from the game-logic FSM through a valid/ready handshake and are applied only at frame boundaries.

Parameters:
IMG_W, 640, background image width in source pixels
IMG_H, 480, background image height in source pixels
SCREEN_W, 640, visible pixels per line
SCREEN_H, 480, visible lines per frame
SCALE_SH, 0, log2 upscale factor; source pixel = screen pixel >> SCALE_SH
IDX_W, 2, palette index width
ADDR_W, 20, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
ROM_LAT, 1, ROM read latency in cycles, 1..3

Ports:
vga_clk  in  1  pixel clock; sole clock
reset  in  1  synchronous, active-high reset
DrawX  in  10  beam x
DrawY  in  10  beam y
blank  in  1  1 = active video (same sense as VGA controller)
scroll_step  in  8  signed scroll delta in source pixels; |step| < IMG_W
scroll_valid  in  1  scroll request valid
scroll_ready  out  1  request slot free
scroll_x  out  ADDR_W  current horizontal offset, 0..IMG_W-1
frame_tick  out  1  one-cycle pulse when the pending scroll is applied
rom_address  out  ADDR_W  to background ROM
rom_q  in  IDX_W  ROM data, ROM_LAT cycles after address
red, green, blue  out  4 each  pixel colour
pal_index  out  IDX_W  to combinational palette
pal_red, pal_green, pal_blue  in  4 each  palette response

Behaviour:
- Stage A, registered: sx = (DrawX >> SCALE_SH) + scroll_x. If sx >= IMG_W, subtract IMG_W once; a single subtract is sufficient. sy = DrawY >> SCALE_SH.
- Stage A rom_address = sy*IMG_W + sx.
- If sy >= IMG_H, set oob flag = 1 and rom_address = 0.
- Elaboration check: (SCREEN_W >> SCALE_SH) <= IMG_W.
- ROM_LAT cycles later, pal_index = rom_q, and the palette colours are combinational on that index.
- Output register: {red,green,blue} = palette colour if delayed blank = 1 and delayed oob = 0; otherwise 0.
- blank and oob travel through a shift pipeline ROM_LAT+1 deep.
- Total latency from DrawX/DrawY/blank to RGB = ROM_LAT + 2 cycles. It is constant and has no bubbles.
- Scroll handshake:
  - A transfer occurs when scroll_valid && scroll_ready.
  - scroll_step is captured into a one-entry pending register.
  - scroll_ready = !pending.
  - The requester must hold scroll_step stable while scroll_valid is high.
- Apply event: the cycle with DrawX == 0 and DrawY == SCREEN_H (first non-visible line). If pending is set at that cycle:
  - scroll_x <= (scroll_x + step) mod IMG_W, using one conditional add or subtract of IMG_W for negative or overflowing results.
  - pending clears.
  - frame_tick = 1 for exactly that cycle.
- If pending is clear at the apply event, frame_tick stays 0 and scroll_x holds.
- Transfer and apply in the same cycle: impossible, because ready = 0 while pending is set. Ready rises the cycle after apply, so at most one scroll is applied per frame.
- scroll_x never changes during visible lines, so there is no tearing.
- Reset, including mid-frame or mid-handshake:
  - scroll_x = 0, pending = 0, scroll_ready = 1 the cycle after reset deasserts.
  - frame_tick = 0, rom_address = 0.
  - Pipeline blank flags = 0, so RGB = 0 until the pipeline refills.
  - A pending request is discarded.

Optional Feature:
Macro: BKG_SCROLL_TRANSPARENT_EN.
- When defined: adds output bkg_transparent (1 bit), aligned with RGB. It is 1 when the delayed palette index == 0 and delayed blank = 1 and delayed oob = 0. Sprite layers use it for colour keying.
- When not defined: the port is absent and behaviour is otherwise identical.

Decomposition:
- Shared package bkg_pkg holds:
  - VGA constants: SCREEN_W, SCREEN_H, coordinate width 10.
  - typedef rgb4_t, a struct of three 4-bit fields.
  - typedef scroll_step_t, signed 8-bit.
  - the modular-add helper function (add with single wrap).
- One sub-module, bkg_scroll_ctrl, holds the pending register, handshake, apply-event detection and scroll_x update. The mapper keeps the address datapath and pipelines.

Test Plan:
- Reset and idle: reset for 3 cycles, then a full frame with scroll_x = 0 and IMG_W = 640. At DrawX = 5, DrawY = 2, rom_address = 1285 is registered one cycle later. RGB appears ROM_LAT+2 cycles after the coordinate and is 0 whenever blank = 0.
- Scroll with wrap: IMG_W = 640, scroll_x = 630, pixel DrawX = 15 -> rom_address x-part = 5. A step of +20 at the apply event -> scroll_x = 10. A step of -20 from scroll_x = 10 -> 630.
- Handshake and backpressure: valid held for 2 frames with steps +4 then +8. The first is accepted and ready drops. It is applied at the first apply event with frame_tick high for 1 cycle. The second is accepted the cycle after. Final scroll_x = 12 after 2 frames.
- Scaling and out-of-bounds: SCALE_SH = 1, IMG_W = 320, IMG_H = 200. DrawX = 7, DrawY = 9 -> address 4*320 + 3 = 1283. DrawY = 420 (sy = 210) -> RGB = 0 with blank = 1.
- Reset mid-frame: a request is pending at DrawY = 100 and reset is pulsed. At the next apply event scroll_x = 0, frame_tick = 0, and scroll_ready = 1 after reset.
- With BKG_SCROLL_TRANSPARENT_EN defined: rom_q = 0 during active video -> bkg_transparent = 1, aligned with RGB. rom_q = 2 -> 0. With blank = 0 -> 0.
